// File: rtl/mcu_debug_engine.sv
// -----------------------------------------------------------------------------
// mcu_debug_engine
// Debug command engine between the serial front end and the target MCU.
// Accepts one decoded command at a time (valid/ready), drives one-cycle MCU
// strobes, waits for completion with a timeout and returns one response per
// command. Adds hardware PC breakpoints, single-step and status read.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op/cmd_addr/cmd_data payload
//   rsp_valid/rsp_ready        response handshake; rsp_data/rsp_err payload
//   pc, mcu_busy, d_rd,        MCU status: program counter, request in progress,
//   mcu_error                  read data and access-failure flag
//   d_in, addr                 request data / address, latched at accept
//   pause, resume, mcu_reset,  one-cycle MCU strobes
//   reg_rd, reg_wr, mem_rd,
//   mem_wr
//   mem_rw_byte                byte-granular qualifier for mem_rd/mem_wr
//   out_valid                  high in every strobe cycle
//   halted                     MCU held paused by the debugger
// -----------------------------------------------------------------------------
module mcu_debug_engine #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int NUM_BP  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    input  logic [AW-1:0] pc,
    input  logic          mcu_busy,
    input  logic [DW-1:0] d_rd,
    input  logic          mcu_error,
    output logic [DW-1:0] d_in,
    output logic [AW-1:0] addr,
    output logic          pause,
    output logic          resume,
    output logic          mcu_reset,
    output logic          reg_rd,
    output logic          reg_wr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          mem_rw_byte,
    output logic          out_valid,
    output logic          halted
);

    localparam int SLOT_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT);

    localparam logic [3:0] OP_PAUSE  = 4'h1, OP_RESUME = 4'h2, OP_RESET  = 4'h3;
    localparam logic [3:0] OP_MEM_RD = 4'h4, OP_MEM_WR = 4'h5, OP_REG_RD = 4'h6;
    localparam logic [3:0] OP_REG_WR = 4'h7, OP_MRD_B  = 4'h8, OP_MWR_B  = 4'h9;
    localparam logic [3:0] OP_BP_SET = 4'hA, OP_BP_CLR = 4'hB, OP_STEP   = 4'hC;
    localparam logic [3:0] OP_STATUS = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Ops that need the MCU halted (memory/register access and single-step).
    function automatic logic needs_halt(input logic [3:0] op);
        return ((op >= OP_MEM_RD) && (op <= OP_MWR_B)) || (op == OP_STEP);
    endfunction

    // Ops that go out to the MCU through ISSUE/WAIT.
    function automatic logic is_remote(input logic [3:0] op);
        return ((op >= OP_PAUSE) && (op <= OP_MWR_B)) || (op == OP_STEP);
    endfunction

    function automatic logic is_read(input logic [3:0] op);
        return (op == OP_MEM_RD) || (op == OP_REG_RD) || (op == OP_MRD_B);
    endfunction

    state_t            state_r, state_nxt_s;
    logic [3:0]        op_r;
    logic [AW-1:0]     bp_pc_r [NUM_BP];
    logic [NUM_BP-1:0] bp_en_r, bp_match_s;
    logic [AW-1:0]     skip_pc_r, pc0_r;
    logic              skip_vld_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [DW-1:0]     status_s;
    logic [SLOT_W-1:0] slot_s;
    logic              accept_s, reject_s, local_s, issue_s, slot_ok_s;
    logic              step_op_s, wait_done_s, wait_tmo_s, wait_end_s, step_end_s;
    logic              step_busy_s, resume_issue_s, bp_hit_s;

    logic              pause_r, resume_r, mcu_reset_r, reg_rd_r, reg_wr_r;
    logic              mem_rd_r, mem_wr_r, mem_rw_byte_r, out_valid_r, halted_r;
    logic              rsp_valid_r, rsp_err_r;
    logic [DW-1:0]     rsp_data_r, d_in_r;
    logic [AW-1:0]     addr_r;
    logic              pause_nxt, resume_nxt, mcu_reset_nxt, reg_rd_nxt, reg_wr_nxt;
    logic              mem_rd_nxt, mem_wr_nxt, mem_rw_byte_nxt, out_valid_nxt, halted_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [DW-1:0]     rsp_data_nxt;

    // cmd_ready is a pure decode of state registers so it reads 1 straight out of reset.
    assign cmd_ready   = (state_r == ST_IDLE) && !rsp_valid_r;
    assign pause       = pause_r;
    assign resume      = resume_r;
    assign mcu_reset   = mcu_reset_r;
    assign reg_rd      = reg_rd_r;
    assign reg_wr      = reg_wr_r;
    assign mem_rd      = mem_rd_r;
    assign mem_wr      = mem_wr_r;
    assign mem_rw_byte = mem_rw_byte_r;
    assign out_valid   = out_valid_r;
    assign halted      = halted_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_err     = rsp_err_r;
    assign d_in        = d_in_r;
    assign addr        = addr_r;

    assign accept_s    = cmd_valid && cmd_ready;
    assign slot_s      = cmd_data[SLOT_W-1:0];
    assign slot_ok_s   = (32'(slot_s) < 32'(NUM_BP));
    assign reject_s    = needs_halt(cmd_op) && !halted_r;
    assign local_s     = !is_remote(cmd_op) || reject_s;
    assign issue_s     = accept_s && !local_s;
    assign step_op_s   = (op_r == OP_STEP);
    // A step completes on PC movement, everything else on the MCU dropping busy.
    assign wait_done_s = step_op_s ? (pc != pc0_r) : !mcu_busy;
    assign wait_tmo_s  = !wait_done_s && (wait_cnt_r == CNT_W'(TIMEOUT - 1));
    assign wait_end_s  = (state_r == ST_WAIT) && (wait_done_s || wait_tmo_s);
    assign step_end_s  = wait_end_s && step_op_s;
    assign step_busy_s = ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) && step_op_s;
    assign resume_issue_s = (state_r == ST_ISSUE) && ((op_r == OP_RESUME) || (op_r == OP_STEP));
    // skip_pc masks the breakpoint we just resumed from until the PC moves off it.
    assign bp_hit_s    = !halted_r && !step_busy_s && !resume_issue_s && (|bp_match_s) &&
                         !(skip_vld_r && (pc == skip_pc_r));

    // Per-slot breakpoint compare against the live PC.
    always_comb begin
        bp_match_s = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_match_s[i] = bp_en_r[i] && (bp_pc_r[i] == pc);
        end
    end

    // Status word: halted in bit 0, enable mask above it.
    always_comb begin
        status_s = '0;
        status_s[0] = halted_r;
        status_s[NUM_BP:1] = bp_en_r;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = local_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_end_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of every registered output.
    always_comb begin
        pause_nxt     = 1'b0;
        resume_nxt    = 1'b0;
        mcu_reset_nxt = 1'b0;
        reg_rd_nxt    = 1'b0;
        reg_wr_nxt    = 1'b0;
        mem_rd_nxt    = 1'b0;
        mem_wr_nxt    = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = '0;
        rsp_err_nxt   = 1'b0;
        if (issue_s) begin
            case (cmd_op)
                OP_PAUSE:             pause_nxt     = 1'b1;
                OP_RESUME, OP_STEP:   resume_nxt    = 1'b1;
                OP_RESET:             mcu_reset_nxt = 1'b1;
                OP_MEM_RD, OP_MRD_B:  mem_rd_nxt    = 1'b1;
                OP_MEM_WR, OP_MWR_B:  mem_wr_nxt    = 1'b1;
                OP_REG_RD:            reg_rd_nxt    = 1'b1;
                OP_REG_WR:            reg_wr_nxt    = 1'b1;
                default:              pause_nxt     = 1'b0;
            endcase
            mem_rw_byte_nxt = (cmd_op == OP_MRD_B) || (cmd_op == OP_MWR_B);
        end else begin
            mem_rw_byte_nxt = 1'b0;
        end
        // Breakpoint hits and step completion re-pause the MCU.
        pause_nxt = pause_nxt | bp_hit_s | step_end_s;
        out_valid_nxt = pause_nxt | resume_nxt | mcu_reset_nxt | reg_rd_nxt |
                        reg_wr_nxt | mem_rd_nxt | mem_wr_nxt;

        case (state_r)
            ST_IDLE: begin
                if (accept_s && local_s) begin
                    rsp_valid_nxt = 1'b1;
                    if (reject_s || (cmd_op >= 4'hE)) begin
                        rsp_err_nxt = 1'b1;
                    end else if ((cmd_op == OP_BP_SET) || (cmd_op == OP_BP_CLR)) begin
                        rsp_err_nxt = !slot_ok_s;
                    end else begin
                        rsp_err_nxt = 1'b0;
                    end
                    rsp_data_nxt = ((cmd_op == OP_STATUS) && !reject_s) ? status_s : '0;
                end else begin
                    rsp_valid_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wait_end_s) begin
                    rsp_valid_nxt = 1'b1;
                    if (wait_tmo_s) begin
                        rsp_err_nxt = 1'b1;
                    end else if (step_op_s) begin
                        rsp_data_nxt = DW'(pc);
                    end else begin
                        rsp_data_nxt = is_read(op_r) ? d_rd : '0;
                        rsp_err_nxt  = mcu_error;
                    end
                end else begin
                    rsp_valid_nxt = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                end else begin
                    rsp_valid_nxt = rsp_valid_r;
                    rsp_data_nxt  = rsp_data_r;
                    rsp_err_nxt   = rsp_err_r;
                end
            end
            default: rsp_valid_nxt = 1'b0;
        endcase

        // Run-control changes take effect at the end of the ISSUE cycle.
        if (state_r == ST_ISSUE) begin
            case (op_r)
                OP_PAUSE:                     halted_nxt = 1'b1;
                OP_RESUME, OP_RESET, OP_STEP: halted_nxt = 1'b0;
                default:                      halted_nxt = halted_r;
            endcase
        end else if (step_end_s) begin
            halted_nxt = 1'b1;
        end else begin
            halted_nxt = halted_r;
        end
        halted_nxt = halted_nxt | bp_hit_s;
    end

    // Command latches, breakpoint table, skip/step tracking and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_r          <= 4'h0;
            bp_en_r       <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_pc_r[i] <= '0;
            end
            skip_pc_r     <= '0;
            skip_vld_r    <= 1'b0;
            pc0_r         <= '0;
            wait_cnt_r    <= '0;
            pause_r       <= 1'b0;
            resume_r      <= 1'b0;
            mcu_reset_r   <= 1'b0;
            reg_rd_r      <= 1'b0;
            reg_wr_r      <= 1'b0;
            mem_rd_r      <= 1'b0;
            mem_wr_r      <= 1'b0;
            mem_rw_byte_r <= 1'b0;
            out_valid_r   <= 1'b0;
            halted_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= '0;
            rsp_err_r     <= 1'b0;
            d_in_r        <= '0;
            addr_r        <= '0;
        end else begin
            if (accept_s) begin
                op_r   <= cmd_op;
                addr_r <= cmd_addr;
                d_in_r <= cmd_data;
                if ((cmd_op == OP_BP_SET) && slot_ok_s) begin
                    bp_pc_r[slot_s] <= cmd_addr;
                    bp_en_r[slot_s] <= 1'b1;
                end
                if ((cmd_op == OP_BP_CLR) && slot_ok_s) begin
                    bp_en_r[slot_s] <= 1'b0;
                end
            end
            if (resume_issue_s) begin
                skip_pc_r  <= pc;
                skip_vld_r <= 1'b1;
                pc0_r      <= pc;
            end else if (skip_vld_r && (pc != skip_pc_r)) begin
                skip_vld_r <= 1'b0;
            end
            wait_cnt_r    <= (state_r == ST_WAIT) ? (wait_cnt_r + CNT_W'(1)) : '0;
            pause_r       <= pause_nxt;
            resume_r      <= resume_nxt;
            mcu_reset_r   <= mcu_reset_nxt;
            reg_rd_r      <= reg_rd_nxt;
            reg_wr_r      <= reg_wr_nxt;
            mem_rd_r      <= mem_rd_nxt;
            mem_wr_r      <= mem_wr_nxt;
            mem_rw_byte_r <= mem_rw_byte_nxt;
            out_valid_r   <= out_valid_nxt;
            halted_r      <= halted_nxt;
            rsp_valid_r   <= rsp_valid_nxt;
            rsp_data_r    <= rsp_data_nxt;
            rsp_err_r     <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_mcu_debug_engine.sv
// -----------------------------------------------------------------------------
// tb_mcu_debug_engine
// Directed self-checking bench for mcu_debug_engine (NUM_BP=3, TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_mcu_debug_engine;

    localparam int DW = 32, AW = 32, NUM_BP = 3, TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_addr, pc, addr;
    logic [DW-1:0] cmd_data, rsp_data, d_rd, d_in;
    logic          mcu_busy, mcu_error, pause, resume, mcu_reset, reg_rd, reg_wr;
    logic          mem_rd, mem_wr, mem_rw_byte, out_valid, halted;

    int            n_total = 0, n_pass = 0;
    logic [DW-1:0] r_data;
    logic          r_err;
    int            r_lat;
    int            acc;

    mcu_debug_engine #(.DW(DW), .AW(AW), .NUM_BP(NUM_BP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .pc(pc), .mcu_busy(mcu_busy), .d_rd(d_rd), .mcu_error(mcu_error),
        .d_in(d_in), .addr(addr), .pause(pause), .resume(resume), .mcu_reset(mcu_reset),
        .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rw_byte(mem_rw_byte), .out_valid(out_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one command; returns one time unit after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_before_send", {63'd0, cmd_ready}, 64'd1);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, capture it, then let the handshake edge pass.
    task automatic get_rsp(input int budget);
        r_lat = 0;
        while (!rsp_valid && r_lat < budget) begin
            tick();
            r_lat++;
        end
        check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
        r_data = rsp_data;
        r_err  = rsp_err;
        tick();
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b1; pc = '0; mcu_busy = 1'b0; d_rd = '0; mcu_error = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_halted",    halted,    1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_pause",     pause,     1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);

        // STATUS straight after reset.
        send(4'hD, 32'h0, 32'h0);
        get_rsp(4);
        check("status0_data", r_data, 32'h0);
        check("status0_err",  r_err,  1'b0);

        // Accesses and STEP are rejected while the MCU runs.
        send(4'h9, 32'h200, 32'hAB);
        check("rej_mem_wr",    mem_wr,    1'b0);
        check("rej_out_valid", out_valid, 1'b0);
        get_rsp(4);
        check("rej_err", r_err, 1'b1);
        check("rej_lat", r_lat, 0);
        send(4'hC, 32'h0, 32'h0);
        get_rsp(4);
        check("step_run_err", r_err, 1'b1);
        send(4'hE, 32'h0, 32'h0);
        get_rsp(4);
        check("illegal_err", r_err, 1'b1);
        send(4'hA, 32'h80, 32'd3);
        get_rsp(4);
        check("bp_slot_range_err", r_err, 1'b1);

        // PAUSE.
        send(4'h1, 32'h0, 32'h0);
        check("pause_strobe", pause, 1'b1);
        check("pause_ov",     out_valid, 1'b1);
        get_rsp(10);
        check("pause_err",    r_err,  1'b0);
        check("pause_data",   r_data, 32'h0);
        check("pause_halted", halted, 1'b1);

        // MEM_RD with busy held through three WAIT cycles.
        d_rd = 32'hDEADBEEF; mcu_busy = 1'b1;
        send(4'h4, 32'h100, 32'h0);
        check("mrd_strobe", mem_rd, 1'b1);
        check("mrd_addr",   addr, 32'h100);
        check("mrd_byte",   mem_rw_byte, 1'b0);
        acc = 0;
        repeat (3) begin
            tick();
            acc += int'(mem_rd);
        end
        mcu_busy = 1'b0;
        get_rsp(10);
        check("mrd_one_strobe", acc, 0);
        check("mrd_data", r_data, 32'hDEADBEEF);
        check("mrd_err",  r_err,  1'b0);

        // REG_RD best case: ISSUE, WAIT, then RESP two edges after accept.
        d_rd = 32'h12345678; mcu_error = 1'b1;
        send(4'h6, 32'h5, 32'h0);
        check("rrd_strobe", reg_rd, 1'b1);
        get_rsp(10);
        check("rrd_lat",  r_lat, 2);
        check("rrd_data", r_data, 32'h12345678);
        check("rrd_err",  r_err,  1'b1);
        mcu_error = 1'b0;

        // Byte read qualifier.
        send(4'h8, 32'h101, 32'h0);
        check("mrdb_strobe", mem_rd, 1'b1);
        check("mrdb_byte",   mem_rw_byte, 1'b1);
        get_rsp(10);

        // MEM_WR with busy stuck: TIMEOUT WAIT cycles, then RESP.
        mcu_busy = 1'b1;
        send(4'h5, 32'h104, 32'hCAFEF00D);
        check("mwr_strobe", mem_wr, 1'b1);
        check("mwr_d_in",   d_in, 32'hCAFEF00D);
        get_rsp(40);
        check("tmo_lat",  r_lat, TIMEOUT + 1);
        check("tmo_err",  r_err, 1'b1);
        check("tmo_data", r_data, 32'h0);
        mcu_busy = 1'b0;

        // Breakpoint in slot 1 at 0x40, resume and ramp the PC into it.
        pc = 32'h38;
        send(4'hA, 32'h40, 32'd1);
        get_rsp(4);
        check("bpset_err", r_err, 1'b0);
        send(4'h2, 32'h0, 32'h0);
        check("resume_strobe", resume, 1'b1);
        get_rsp(10);
        check("resume_halted", halted, 1'b0);
        pc = 32'h3C;
        tick();
        check("bp_no_hit_3c", pause, 1'b0);
        pc = 32'h40;
        tick();
        check("bp_hit_pause",  pause,  1'b1);
        check("bp_hit_halted", halted, 1'b1);
        tick();
        check("bp_pause_1cyc", pause, 1'b0);

        send(4'hD, 32'h0, 32'h0);
        get_rsp(4);
        check("status_bp", r_data, 32'h5);

        // STEP from 0x40 to 0x44.
        send(4'hC, 32'h0, 32'h0);
        check("step_resume", resume, 1'b1);
        tick();
        check("step_running", halted, 1'b0);
        check("step_no_pause", pause, 1'b0);
        pc = 32'h44;
        tick();
        check("step_pause",  pause,  1'b1);
        check("step_halted", halted, 1'b1);
        get_rsp(4);
        check("step_data", r_data, 32'h44);
        check("step_err",  r_err,  1'b0);

        // RESUME while sitting on the breakpoint must not re-trap.
        pc = 32'h40;
        send(4'h2, 32'h0, 32'h0);
        get_rsp(10);
        acc = 0;
        repeat (3) begin
            tick();
            acc += int'(pause);
        end
        check("skip_no_retrap", acc, 0);
        check("skip_running", halted, 1'b0);
        pc = 32'h44;
        tick();
        pc = 32'h40;
        tick();
        check("rearm_hit", pause, 1'b1);

        // Clear slot 1, then hold the STATUS response with rsp_ready low.
        send(4'hB, 32'h0, 32'd1);
        get_rsp(4);
        check("bpclr_err", r_err, 1'b0);
        rsp_ready = 1'b0;
        send(4'hD, 32'h0, 32'h0);
        repeat (5) begin
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data",  rsp_data,  32'h1);
            check("hold_ready", cmd_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("hold_release", rsp_valid, 1'b0);
        check("hold_ready_back", cmd_ready, 1'b1);

        // Reset while waiting on the MCU.
        mcu_busy = 1'b1;
        send(4'h4, 32'h300, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_ov",     out_valid, 1'b0);
        check("mid_rst_rvalid", rsp_valid, 1'b0);
        check("mid_rst_halted", halted,    1'b0);
        check("mid_rst_addr",   addr,      32'h0);
        check("mid_rst_data",   rsp_data,  32'h0);
        reset = 1'b1;
        mcu_busy = 1'b0;
        acc = 0;
        repeat (5) begin
            tick();
            acc += int'(out_valid) + int'(rsp_valid);
        end
        check("post_rst_quiet", acc, 0);
        send(4'hD, 32'h0, 32'h0);
        get_rsp(4);
        check("post_rst_status", r_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
